// File: rtl/eth_vlg_pkt_buf_wr_if.sv
// Bundle of stream input, RAM write port, consumer release pointer and descriptor
// output for the packet buffer write side. slave is the framer, master is its environment.
interface eth_vlg_pkt_buf_wr_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic [DW-1:0] in_d;
  logic          in_v;
  logic          in_sop;
  logic          in_eop;
  logic          in_err;
  logic          in_rdy;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_w;
  logic [AW:0]   rd_ptr;
  logic          desc_v;
  logic [AW-1:0] desc_addr;
  logic [AW:0]   desc_len;
  logic          desc_rdy;

  modport master (
    output in_d, in_v, in_sop, in_eop, in_err, rd_ptr, desc_rdy,
    input  in_rdy, ram_a, ram_d, ram_w, desc_v, desc_addr, desc_len
  );

  modport slave (
    input  in_d, in_v, in_sop, in_eop, in_err, rd_ptr, desc_rdy,
    output in_rdy, ram_a, ram_d, ram_w, desc_v, desc_addr, desc_len
  );
endinterface

// File: rtl/eth_vlg_pkt_buf_wr.sv
// Write-side packet framer: streams bytes into a circular RAM and publishes a descriptor
// per good packet. Define ETH_VLG_PKT_BUF_WR_STATS_EN to add pkt_cnt/drop_cnt counters.
module eth_vlg_pkt_buf_wr #(
  parameter int AW      = 12,
  parameter int DW      = 8,
  parameter int MAX_LEN = 1518
) (
  input logic clk,
  input logic rst_n,
  eth_vlg_pkt_buf_wr_if.slave bus
`ifdef ETH_VLG_PKT_BUF_WR_STATS_EN
  ,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int          PW        = AW + 1;
  localparam logic [AW:0] MAX_LEN_C = PW'(MAX_LEN);
  localparam logic [AW:0] CAPACITY  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cur_ptr_q, cur_ptr_d;
  logic [AW:0]   start_ptr_q, start_ptr_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   rd_ptr_q;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [DW-1:0] ram_d_q, ram_d_d;
  logic          ram_w_q, ram_w_d;
  logic          desc_v_q, desc_v_d;
  logic [AW-1:0] desc_addr_q, desc_addr_d;
  logic [AW:0]   desc_len_q, desc_len_d;

  logic [AW:0]   used;
  logic          full;
  logic          rdy;
  logic          accept;
  logic          commit;
  logic [AW:0]   base;

  // rd_ptr is registered so a release only frees space from the following cycle on
  assign used   = cur_ptr_q - rd_ptr_q;
  assign full   = (used == CAPACITY);
  assign accept = bus.in_v && rdy;

  // Ready blocks any beat that could commit while the single descriptor slot is occupied
  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      S_IDLE:  rdy = !full && !desc_v_q;
      S_WRITE: rdy = !full && !(bus.in_eop && desc_v_q);
      default: rdy = bus.in_sop ? (!full && !desc_v_q) : 1'b1;
    endcase
    rdy = rdy && rst_n;
  end

  always_comb begin
    state_d     = state_q;
    cur_ptr_d   = cur_ptr_q;
    start_ptr_d = start_ptr_q;
    len_d       = len_q;
    ram_w_d     = 1'b0;
    ram_a_d     = ram_a_q;
    ram_d_d     = ram_d_q;
    desc_v_d    = desc_v_q && !bus.desc_rdy;
    desc_addr_d = desc_addr_q;
    desc_len_d  = desc_len_q;
    commit      = 1'b0;
    // A sop mid-packet restarts at the current packet's start, rewinding it
    base        = (state_q == S_WRITE) ? start_ptr_q : cur_ptr_q;

    if (accept) begin
      if (bus.in_sop) begin
        if (bus.in_eop && bus.in_err) begin
          cur_ptr_d = base;
          state_d   = S_IDLE;
        end else begin
          ram_w_d     = 1'b1;
          ram_a_d     = base[AW-1:0];
          ram_d_d     = bus.in_d;
          start_ptr_d = base;
          cur_ptr_d   = base + PW'(1);
          len_d       = PW'(1);
          commit      = bus.in_eop;
          state_d     = bus.in_eop ? S_IDLE : S_WRITE;
        end
      end else if (state_q == S_WRITE) begin
        if (len_q == MAX_LEN_C) begin
          cur_ptr_d = start_ptr_q;
          state_d   = bus.in_eop ? S_IDLE : S_DROP;
        end else if (bus.in_eop && bus.in_err) begin
          cur_ptr_d = start_ptr_q;
          state_d   = S_IDLE;
        end else begin
          ram_w_d   = 1'b1;
          ram_a_d   = cur_ptr_q[AW-1:0];
          ram_d_d   = bus.in_d;
          cur_ptr_d = cur_ptr_q + PW'(1);
          len_d     = len_q + PW'(1);
          commit    = bus.in_eop;
          state_d   = bus.in_eop ? S_IDLE : S_WRITE;
        end
      end else if (bus.in_eop) begin
        state_d = S_IDLE;
      end
    end

    if (commit) begin
      desc_v_d    = 1'b1;
      desc_addr_d = start_ptr_d[AW-1:0];
      desc_len_d  = len_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_ptr_q   <= '0;
      start_ptr_q <= '0;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      ram_w_q     <= 1'b0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      desc_v_q    <= 1'b0;
      desc_addr_q <= '0;
      desc_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_ptr_q   <= cur_ptr_d;
      start_ptr_q <= start_ptr_d;
      len_q       <= len_d;
      rd_ptr_q    <= bus.rd_ptr;
      ram_w_q     <= ram_w_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      desc_v_q    <= desc_v_d;
      desc_addr_q <= desc_addr_d;
      desc_len_q  <= desc_len_d;
    end
  end

  assign bus.in_rdy    = rdy;
  assign bus.ram_w     = ram_w_q;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_d     = ram_d_q;
  assign bus.desc_v    = desc_v_q;
  assign bus.desc_addr = desc_addr_q;
  assign bus.desc_len  = desc_len_q;

`ifdef ETH_VLG_PKT_BUF_WR_STATS_EN
  logic drop_ev;

  // Orphan data counts once, on the eop that closes the run
  assign drop_ev = accept && (
      (bus.in_sop && state_q == S_WRITE) ||
      (bus.in_sop && bus.in_eop && bus.in_err) ||
      (!bus.in_sop && state_q == S_WRITE && (len_q == MAX_LEN_C || (bus.in_eop && bus.in_err))) ||
      (!bus.in_sop && state_q == S_IDLE && bus.in_eop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
      if (drop_ev && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/eth_vlg_pkt_buf_wr.md
Name: eth_vlg_pkt_buf_wr

Overview:
- Write-side packet framer for a dual-port packet RAM.
- Accepts a byte stream framed by sop/eop with valid/ready, and writes bytes into a circular RAM region through one write port.
- On a good eop, publishes a descriptor (start address, length) to the downstream reader.
- Errored, truncated or oversize packets are rewound and never become visible. Free space is tracked against a read pointer returned by the consumer.

Parameters:
- AW, 12, RAM address width; buffer holds 2**AW bytes.
- DW, 8, data width; fixed byte stream.
- MAX_LEN, 1518, longest accepted packet in bytes; must be <= 2**AW.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- in_d  in  DW  stream byte
- in_v  in  1  byte valid
- in_sop  in  1  first byte of packet
- in_eop  in  1  last byte of packet
- in_err  in  1  packet error, sampled with in_eop
- in_rdy  out  1  block accepts byte this cycle
- ram_a  out  AW  RAM write address
- ram_d  out  DW  RAM write data
- ram_w  out  1  RAM write enable
- rd_ptr  in  AW+1  consumer release pointer; wraps mod 2**(AW+1)
- desc_v  out  1  descriptor valid
- desc_addr  out  AW  packet start address
- desc_len  out  AW+1  packet length in bytes, 1..MAX_LEN
- desc_rdy  in  1  consumer takes descriptor

Behaviour:
- Accept condition: in_v && in_rdy.
- Reset values: in_rdy=0 during reset; ram_a=0, ram_d=0, ram_w=0, desc_v=0, desc_addr=0, desc_len=0. Internal pointers: cur_ptr=0, start_ptr=0, len=0. State=IDLE.
- Pointers are AW+1 bits wide. RAM address is ptr[AW-1:0]. Wrap from 2**AW-1 to 0 is natural modulo.
- Occupancy: used = cur_ptr - rd_ptr (mod 2**(AW+1)); full when used == 2**AW.
- States:
  - IDLE
    - in_rdy = !full && !desc_v.
    - Accepted byte with sop: write it, len=1, start_ptr=cur_ptr, go to WRITE.
    - sop&&eop in the same beat: one-byte packet; commits directly (good) or rewinds (err), stays in IDLE.
    - Accepted byte without sop: discarded, no RAM write, stay in IDLE.
  - WRITE
    - in_rdy = !full.
    - Each accepted byte: ram_w=1 next cycle with ram_a=cur_ptr, ram_d=in_d. Then cur_ptr+1, len+1.
    - eop without err, and desc_v==0: commit. desc_v=1 next cycle, desc_addr=start_ptr[AW-1:0], desc_len=len including this byte. Go to IDLE.
    - eop without err while desc_v==1: cannot occur; in_rdy is held low on the eop beat whenever desc_v=1.
    - eop with err: cur_ptr rewinds to start_ptr, no descriptor, go to IDLE. The eop byte itself is not written.
    - sop mid-packet: current packet rewound; the new sop byte starts a fresh packet at start_ptr.
    - Accepting a byte that would make len > MAX_LEN: rewind, go to DROP. That byte is not written.
  - DROP
    - in_rdy = 1 (no RAM writes).
    - Discard through eop, then go to IDLE.
    - A sop in DROP starts a new packet as in IDLE.
- Write latency: RAM write occurs 1 cycle after acceptance.
- Descriptor latency: desc_v asserts 1 cycle after the accepted eop.
- Descriptor is a one-deep register. desc_v holds, with stable fields, until desc_v && desc_rdy, then clears next cycle. While desc_v=1 in IDLE, in_rdy=0.
- Rewound bytes already written to RAM are not visible and are overwritten by the next packet. rd_ptr never passes start_ptr.
- Simultaneous free and full: rd_ptr advancing in the same cycle takes effect next cycle (in_rdy is computed from registered state).
- Asynchronous reset mid-packet: all state clears immediately; a partial packet is lost and no descriptor is emitted.

Optional Feature:
- Macro: ETH_VLG_PKT_BUF_WR_STATS_EN.
- Defined: adds outputs pkt_cnt (32 bits, +1 per committed descriptor) and drop_cnt (32 bits, +1 per errored, truncated-by-sop, oversize or orphan-data packet).
  - Both counters saturate at all-ones and reset to 0.
  - An orphan run counts once per byte burst ending in eop.
- Undefined: the ports and logic are absent; functional behaviour is otherwise identical.

Test Plan:
- Single good packet: 64 bytes 0x00..0x3F at cur_ptr=0, desc_rdy=1. Expect 64 writes at addr 0..63, then desc_v for 1 cycle with desc_addr=0, desc_len=64.
- Wrap: preload cur_ptr=rd_ptr=4090, send a 10-byte packet. Expect writes to 4090..4095 then 0..3; desc_addr=4090, desc_len=10.
- Error rewind: 20-byte packet with in_err on eop, then a 5-byte good packet. Expect no descriptor for the first; the second gets desc_addr equal to the first packet's start, desc_len=5.
- Oversize: 1600-byte packet. Expect 1518 writes, rewind, remaining bytes accepted without writes, no descriptor. A following 60-byte packet commits at the original start.
- Backpressure: rd_ptr held at 0, stream 4096+ bytes in 1500-byte packets. Expect in_rdy=0 once used=4096. Advancing rd_ptr by 100 re-asserts in_rdy the next cycle.
- Descriptor stall: desc_rdy=0, send two 1-byte sop&eop packets. Expect the second held (in_rdy=0) until desc_rdy pulses, then desc_addr=1, desc_len=1.
